// File: rtl/reorder_buffer_pkg.sv
// Shared sizing constants and the entry record for the reorder buffer.
// Contents:
//   ROB_ENTRIES / NUM_AREGS / NUM_PREGS - buffer depth and register file sizes
//   IW / AW / PW                        - index, arch-reg and phys-reg widths
//   EXC_VECTOR                          - fetch target after an exception
//   rob_entry_t                         - one buffer slot
package reorder_buffer_pkg;

    localparam int unsigned ROB_ENTRIES = 32;
    localparam int unsigned NUM_AREGS   = 32;
    localparam int unsigned NUM_PREGS   = 64;
    localparam logic [31:0] EXC_VECTOR  = 32'h100;

    localparam int unsigned IW = $clog2(ROB_ENTRIES);
    localparam int unsigned AW = $clog2(NUM_AREGS);
    localparam int unsigned PW = $clog2(NUM_PREGS);

    typedef struct packed {
        logic          valid;
        logic          done;
        logic          has_dst;
        logic [AW-1:0] dst_areg;
        logic [PW-1:0] dst_preg;
        logic [PW-1:0] old_preg;
        logic [31:0]   pc;
        logic [31:0]   val;
        logic          br_mispred;
        logic          exception;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Execute -> reorder buffer result path.
// Signals:
//   ex_valid      - a result is being delivered this cycle
//   rob_entry_idx - buffer slot the result belongs to
//   ex_val        - result value; resolved target PC for branches
//   br_mispred    - branch direction was mispredicted
//   exception     - instruction raised an exception
// Modports: master (execute side, drives), slave (buffer side, receives).
interface reorder_buffer_if;
    import reorder_buffer_pkg::*;

    logic          ex_valid;
    logic [IW-1:0] rob_entry_idx;
    logic [31:0]   ex_val;
    logic          br_mispred;
    logic          exception;

    modport master (
        output ex_valid,
        output rob_entry_idx,
        output ex_val,
        output br_mispred,
        output exception
    );

    modport slave (
        input ex_valid,
        input rob_entry_idx,
        input ex_val,
        input br_mispred,
        input exception
    );

endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement buffer. Allocates one slot per dispatched instruction,
// records execute results, retires done slots in program order (one per
// cycle) and raises a one-cycle flush when the head mispredicted or faulted.
// Ports:
//   clk, rst                   - clock; asynchronous active-low reset
//   alloc_valid/alloc_ready    - dispatch handshake
//   alloc_pc/has_dst/dst_areg/dst_preg/old_preg - dispatched instruction
//   alloc_idx                  - slot given to the instruction being offered
//   ex                         - execute result path (slave side)
//   commit_*                   - retiring head entry
//   flush_valid, redirect_pc   - one-cycle squash and fetch target
//   empty, full, count         - occupancy
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic           clk,
    input  logic           rst,

    input  logic           alloc_valid,
    output logic           alloc_ready,
    input  logic [31:0]    alloc_pc,
    input  logic           alloc_has_dst,
    input  logic [AW-1:0]  alloc_dst_areg,
    input  logic [PW-1:0]  alloc_dst_preg,
    input  logic [PW-1:0]  alloc_old_preg,
    output logic [IW-1:0]  alloc_idx,

    reorder_buffer_if.slave ex,

    output logic           commit_valid,
    output logic           commit_has_dst,
    output logic [AW-1:0]  commit_dst_areg,
    output logic [PW-1:0]  commit_dst_preg,
    output logic [PW-1:0]  commit_old_preg,
    output logic [31:0]    commit_pc,

    output logic           flush_valid,
    output logic [31:0]    redirect_pc,

    output logic           empty,
    output logic           full,
    output logic [IW:0]    count
);

    rob_entry_t  entries_q [ROB_ENTRIES];
    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [IW:0] head_q;
    logic [IW:0] tail_q;
    logic        flush_q;
    logic [31:0] redirect_q;

    rob_entry_t  head_entry;
    rob_entry_t  alloc_entry;
    logic        head_ready;
    logic        head_flush;
    logic        alloc_fire;
    logic        wb_fire;

    always_comb begin
        head_entry = entries_q[head_q[IW-1:0]];
        // The flush cycle itself retires nothing.
        head_ready = head_entry.valid && head_entry.done && !flush_q;
        head_flush = head_ready && (head_entry.exception || head_entry.br_mispred);

        empty = (head_q == tail_q);
        full  = (head_q[IW-1:0] == tail_q[IW-1:0]) && (head_q[IW] != tail_q[IW]);
        count = tail_q - head_q;

        alloc_ready = !full && !flush_q;
        alloc_fire  = alloc_valid && alloc_ready;
        alloc_idx   = tail_q[IW-1:0];

        wb_fire = ex.ex_valid && !flush_q && entries_q[ex.rob_entry_idx].valid;

        // A mispredicted branch still retires; only an exception suppresses it.
        commit_valid    = head_ready && !head_entry.exception;
        commit_has_dst  = head_entry.has_dst;
        commit_dst_areg = head_entry.dst_areg;
        commit_dst_preg = head_entry.dst_preg;
        commit_old_preg = head_entry.old_preg;
        commit_pc       = head_entry.pc;

        alloc_entry            = '0;
        alloc_entry.valid      = 1'b1;
        alloc_entry.has_dst    = alloc_has_dst;
        alloc_entry.dst_areg   = alloc_dst_areg;
        alloc_entry.dst_preg   = alloc_dst_preg;
        alloc_entry.old_preg   = alloc_old_preg;
        alloc_entry.pc         = alloc_pc;
    end

    assign flush_valid = flush_q;
    assign redirect_pc = redirect_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ROB_ENTRIES; i++) begin
                entries_q[i] <= '0;
            end
            head_q     <= '0;
            tail_q     <= '0;
            flush_q    <= 1'b0;
            redirect_q <= '0;
        end else begin
            flush_q    <= head_flush;
            redirect_q <= head_flush ? (head_entry.exception ? EXC_VECTOR : head_entry.val)
                                     : '0;
            if (head_flush) begin
                // Squash everything, including any allocation offered this cycle.
                for (int i = 0; i < ROB_ENTRIES; i++) begin
                    entries_q[i].valid <= 1'b0;
                    entries_q[i].done  <= 1'b0;
                end
                head_q <= '0;
                tail_q <= '0;
            end else begin
                if (wb_fire) begin
                    entries_q[ex.rob_entry_idx].done       <= 1'b1;
                    entries_q[ex.rob_entry_idx].val        <= ex.ex_val;
                    entries_q[ex.rob_entry_idx].br_mispred <= ex.br_mispred;
                    entries_q[ex.rob_entry_idx].exception  <= ex.exception;
                end
                // Placed after the writeback so a late write to the head cannot revive it.
                if (commit_valid) begin
                    entries_q[head_q[IW-1:0]].valid <= 1'b0;
                    entries_q[head_q[IW-1:0]].done  <= 1'b0;
                    head_q <= head_q + 1'b1;
                end
                if (alloc_fire) begin
                    entries_q[tail_q[IW-1:0]] <= alloc_entry;
                    tail_q <= tail_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: a program-order queue model checked
// every cycle on the falling edge, plus directed scenarios with literal checks.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic           clk;
    logic           rst;
    logic           alloc_valid;
    logic           alloc_ready;
    logic [31:0]    alloc_pc;
    logic           alloc_has_dst;
    logic [AW-1:0]  alloc_dst_areg;
    logic [PW-1:0]  alloc_dst_preg;
    logic [PW-1:0]  alloc_old_preg;
    logic [IW-1:0]  alloc_idx;
    logic           commit_valid;
    logic           commit_has_dst;
    logic [AW-1:0]  commit_dst_areg;
    logic [PW-1:0]  commit_dst_preg;
    logic [PW-1:0]  commit_old_preg;
    logic [31:0]    commit_pc;
    logic           flush_valid;
    logic [31:0]    redirect_pc;
    logic           empty;
    logic           full;
    logic [IW:0]    count;

    reorder_buffer_if ex_if ();

    reorder_buffer dut (
        .clk             (clk),
        .rst             (rst),
        .alloc_valid     (alloc_valid),
        .alloc_ready     (alloc_ready),
        .alloc_pc        (alloc_pc),
        .alloc_has_dst   (alloc_has_dst),
        .alloc_dst_areg  (alloc_dst_areg),
        .alloc_dst_preg  (alloc_dst_preg),
        .alloc_old_preg  (alloc_old_preg),
        .alloc_idx       (alloc_idx),
        .ex              (ex_if.slave),
        .commit_valid    (commit_valid),
        .commit_has_dst  (commit_has_dst),
        .commit_dst_areg (commit_dst_areg),
        .commit_dst_preg (commit_dst_preg),
        .commit_old_preg (commit_old_preg),
        .commit_pc       (commit_pc),
        .flush_valid     (flush_valid),
        .redirect_pc     (redirect_pc),
        .empty           (empty),
        .full            (full),
        .count           (count)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- behavioural model: program-order list of instructions
    typedef struct {
        int          idx;
        logic [31:0] pc;
        logic        has_dst;
        logic [AW-1:0] areg;
        logic [PW-1:0] preg;
        logic [PW-1:0] old;
        bit          done;
        logic [31:0] val;
        bit          mis;
        bit          exc;
    } mdl_t;

    mdl_t        mq[$];
    mdl_t        h;
    mdl_t        n;
    int          alloc_seq;   // allocations since the last reset or flush
    bit          m_flush;
    logic [31:0] m_redirect;
    int          sz;
    bit          hd;
    bit          exp_commit;
    bit          take_alloc;

    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_alloc_ready", alloc_ready, 1);
            chk("rst_empty", empty, 1);
            chk("rst_full", full, 0);
            chk("rst_count", count, 0);
            chk("rst_alloc_idx", alloc_idx, 0);
            chk("rst_commit_valid", commit_valid, 0);
            chk("rst_commit_pc", commit_pc, 0);
            chk("rst_commit_preg", commit_dst_preg, 0);
            chk("rst_flush_valid", flush_valid, 0);
            chk("rst_redirect_pc", redirect_pc, 0);
            mq.delete();
            alloc_seq  = 0;
            m_flush    = 0;
            m_redirect = 0;
        end else begin
            sz = mq.size();
            hd = (sz > 0) && mq[0].done && !m_flush;
            if (sz > 0) h = mq[0];
            exp_commit = hd && !h.exc;

            chk("empty", empty, sz == 0);
            chk("full", full, sz == ROB_ENTRIES);
            chk("count", count, sz);
            chk("alloc_ready", alloc_ready, (sz < ROB_ENTRIES) && !m_flush);
            chk("alloc_idx", alloc_idx, alloc_seq % ROB_ENTRIES);
            chk("flush_valid", flush_valid, m_flush);
            if (m_flush) chk("redirect_pc", redirect_pc, m_redirect);
            chk("commit_valid", commit_valid, exp_commit);
            if (exp_commit) begin
                chk("commit_pc", commit_pc, h.pc);
                chk("commit_has_dst", commit_has_dst, h.has_dst);
                chk("commit_dst_areg", commit_dst_areg, h.areg);
                chk("commit_dst_preg", commit_dst_preg, h.preg);
                chk("commit_old_preg", commit_old_preg, h.old);
            end

            // Advance the model to the state after the coming rising edge.
            if (m_flush) begin
                m_flush    = 0;
                m_redirect = 0;
            end else begin
                take_alloc = alloc_valid && (sz < ROB_ENTRIES);
                if (ex_if.ex_valid) begin
                    foreach (mq[i]) begin
                        if (mq[i].idx == int'(ex_if.rob_entry_idx)) begin
                            mq[i].done = 1;
                            mq[i].val  = ex_if.ex_val;
                            mq[i].mis  = ex_if.br_mispred;
                            mq[i].exc  = ex_if.exception;
                        end
                    end
                end
                if (hd && (h.exc || h.mis)) begin
                    m_flush    = 1;
                    m_redirect = h.exc ? 32'h100 : h.val;
                    mq.delete();
                    alloc_seq  = 0;
                end else begin
                    if (hd) void'(mq.pop_front());
                    if (take_alloc) begin
                        n.idx     = alloc_seq % ROB_ENTRIES;
                        n.pc      = alloc_pc;
                        n.has_dst = alloc_has_dst;
                        n.areg    = alloc_dst_areg;
                        n.preg    = alloc_dst_preg;
                        n.old     = alloc_old_preg;
                        n.done    = 0;
                        n.val     = 0;
                        n.mis     = 0;
                        n.exc     = 0;
                        mq.push_back(n);
                        alloc_seq++;
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers
    task automatic idle();
        alloc_valid      = 0;
        alloc_pc         = 0;
        alloc_has_dst    = 0;
        alloc_dst_areg   = 0;
        alloc_dst_preg   = 0;
        alloc_old_preg   = 0;
        ex_if.ex_valid      = 0;
        ex_if.rob_entry_idx = 0;
        ex_if.ex_val        = 0;
        ex_if.br_mispred    = 0;
        ex_if.exception     = 0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic alloc(input logic [31:0] pc, input int areg, input int preg, input int old);
        alloc_valid    = 1;
        alloc_pc       = pc;
        alloc_has_dst  = 1;
        alloc_dst_areg = AW'(areg);
        alloc_dst_preg = PW'(preg);
        alloc_old_preg = PW'(old);
    endtask

    task automatic wb(input int idx, input logic [31:0] val, input bit mis, input bit exc);
        ex_if.ex_valid      = 1;
        ex_if.rob_entry_idx = IW'(idx);
        ex_if.ex_val        = val;
        ex_if.br_mispred    = mis;
        ex_if.exception     = exc;
    endtask

    task automatic do_reset();
        idle();
        rst = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1;
    endtask

    // ---------------- directed scenarios
    initial begin
        idle();
        do_reset();

        // Reset state
        chk("t1_empty", empty, 1);
        chk("t1_full", full, 0);
        chk("t1_count", count, 0);
        chk("t1_alloc_ready", alloc_ready, 1);
        chk("t1_commit_valid", commit_valid, 0);
        chk("t1_flush_valid", flush_valid, 0);

        // Single instruction round trip
        alloc(32'h0, 1, 33, 1);
        chk("t2_alloc_idx", alloc_idx, 0);
        cycle();
        wb(0, 32'd10, 0, 0);
        cycle();
        chk("t2_commit_valid", commit_valid, 1);
        chk("t2_commit_preg", commit_dst_preg, 33);
        chk("t2_commit_old", commit_old_preg, 1);
        cycle();
        chk("t2_empty", empty, 1);

        // Out-of-order completion, in-order retirement
        do_reset();
        alloc(32'h10, 2, 34, 2);
        cycle();
        alloc(32'h14, 3, 35, 3);
        chk("t3_alloc_idx_b", alloc_idx, 1);
        cycle();
        wb(1, 32'd7, 0, 0);
        cycle();
        chk("t3_no_commit", commit_valid, 0);
        wb(0, 32'd6, 0, 0);
        cycle();
        chk("t3_commit_a", commit_valid, 1);
        chk("t3_commit_a_pc", commit_pc, 32'h10);
        cycle();
        chk("t3_commit_b", commit_valid, 1);
        chk("t3_commit_b_pc", commit_pc, 32'h14);
        cycle();
        chk("t3_empty", empty, 1);

        // Fill, full back-pressure, wrap-around
        do_reset();
        for (int i = 0; i < 32; i++) begin
            alloc(32'h1000 + 32'(4 * i), i, 32 + i, i);
            cycle();
        end
        chk("t4_full", full, 1);
        chk("t4_alloc_ready", alloc_ready, 0);
        chk("t4_count", count, 32);
        alloc(32'hdead_0000, 9, 9, 9);
        wb(0, 32'd5, 0, 0);
        cycle();
        chk("t4_commit", commit_valid, 1);
        chk("t4_commit_pc", commit_pc, 32'h1000);
        chk("t4_still_full", alloc_ready, 0);
        cycle();
        chk("t4_ready_again", alloc_ready, 1);
        chk("t4_count31", count, 31);
        chk("t4_wrap_idx", alloc_idx, 0);
        alloc(32'h2000, 3, 40, 3);
        cycle();
        chk("t4_refull", full, 1);
        chk("t4_count32", count, 32);
        for (int i = 1; i <= 32; i++) begin
            wb(i % 32, 32'(i), 0, 0);
            cycle();
        end
        repeat (4) cycle();
        chk("t4_drained", empty, 1);

        // Head mispredict: commits, then flush with resolved target
        do_reset();
        alloc(32'h200, 4, 36, 4);
        chk("t5_alloc_idx", alloc_idx, 0);
        cycle();
        alloc(32'h204, 5, 37, 5);
        cycle();
        alloc(32'h208, 6, 38, 6);
        cycle();
        alloc(32'h20c, 7, 39, 7);
        cycle();
        wb(1, 32'd1, 0, 0);
        cycle();
        wb(2, 32'd2, 0, 0);
        cycle();
        wb(0, 32'h40, 1, 0);
        cycle();
        chk("t5_commit", commit_valid, 1);
        chk("t5_commit_pc", commit_pc, 32'h200);
        chk("t5_no_flush_yet", flush_valid, 0);
        alloc(32'h500, 8, 50, 8);
        cycle();
        chk("t5_flush", flush_valid, 1);
        chk("t5_redirect", redirect_pc, 32'h40);
        chk("t5_no_commit", commit_valid, 0);
        chk("t5_alloc_blocked", alloc_ready, 0);
        wb(0, 32'd3, 0, 0);
        alloc(32'h504, 8, 51, 8);
        cycle();
        chk("t5_flush_done", flush_valid, 0);
        chk("t5_empty", empty, 1);
        chk("t5_quiet", commit_valid, 0);

        // Head exception: no commit, flush to the exception vector
        alloc(32'h300, 9, 41, 9);
        chk("t6_alloc_idx", alloc_idx, 0);
        cycle();
        alloc(32'h304, 10, 42, 10);
        cycle();
        wb(0, 32'h77, 0, 1);
        cycle();
        chk("t6_no_commit", commit_valid, 0);
        cycle();
        chk("t6_flush", flush_valid, 1);
        chk("t6_redirect", redirect_pc, 32'h100);
        chk("t6_count", count, 0);
        cycle();
        chk("t6_flush_done", flush_valid, 0);

        // Writeback to an empty slot, overwrite, alloc alongside commit
        wb(5, 32'd1, 0, 1);
        cycle();
        alloc(32'h400, 11, 43, 11);
        cycle();
        alloc(32'h404, 12, 44, 12);
        cycle();
        wb(1, 32'd0, 0, 1);
        cycle();
        wb(1, 32'h55, 0, 0);
        cycle();
        chk("t7_wait_head", commit_valid, 0);
        wb(0, 32'd1, 0, 0);
        cycle();
        chk("t7_commit0", commit_pc, 32'h400);
        alloc(32'h408, 13, 45, 13);
        cycle();
        chk("t7_commit1", commit_pc, 32'h404);
        chk("t7_no_flush", flush_valid, 0);
        cycle();
        chk("t7_count", count, 1);
        wb(2, 32'd2, 0, 0);
        cycle();
        cycle();
        chk("t7_empty", empty, 1);
        chk("t7_flush_never", flush_valid, 0);

        // Reset mid-operation with an exception pending at the head
        alloc(32'h600, 14, 46, 14);
        cycle();
        wb(3, 32'd0, 0, 1);
        cycle();
        #2;
        rst = 0;
        #1;
        chk("t8_count", count, 0);
        chk("t8_empty", empty, 1);
        chk("t8_commit", commit_valid, 0);
        @(posedge clk);
        #1;
        chk("t8_no_flush", flush_valid, 0);
        rst = 1;
        cycle();
        chk("t8_no_flush_after", flush_valid, 0);
        chk("t8_empty_after", empty, 1);

        repeat (2) cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
